// File: rtl/execute.sv
// Execute stage of the Y86-64 SEQ processor: combinational ALU producing valE,
// the OF/ZF/SF condition-code register, and the jXX/cmovXX condition Cnd.
module execute #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   icode,
   input  logic [3:0]   ifun,
   input  logic [W-1:0] valA,
   input  logic [W-1:0] valB,
   input  logic [W-1:0] valC,
   output logic [W-1:0] valE,
   output logic         Cnd,
   output logic         OF,
   output logic         ZF,
   output logic         SF
);

   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   localparam logic [W-1:0] STACK_STEP = W'(8);

   logic signed [W-1:0] opA;
   logic signed [W-1:0] opB;
   logic signed [W-1:0] aluOut;
   logic                ccWrite;
   logic                nextOF;

   // Branch/move condition from the current flags; unknown conditions never fire.
   function automatic logic evalCond(input logic [3:0] fn, input logic zf,
                                     input logic sf, input logic of);
      logic lt;
      lt = sf ^ of;
      case (fn)
         4'h0:    evalCond = 1'b1;
         4'h1:    evalCond = lt | zf;
         4'h2:    evalCond = lt;
         4'h3:    evalCond = zf;
         4'h4:    evalCond = ~zf;
         4'h5:    evalCond = ~lt;
         4'h6:    evalCond = ~lt & ~zf;
         default: evalCond = 1'b0;
      endcase
   endfunction

   assign opA = signed'(valA);
   assign opB = signed'(valB);

   always_comb begin
      aluOut = '0;
      case (ifun)
         ALU_ADD: aluOut = opB + opA;
         ALU_SUB: aluOut = opB - opA;
         ALU_AND: aluOut = opB & opA;
         ALU_XOR: aluOut = opB ^ opA;
         default: aluOut = '0;
      endcase
   end

   always_comb begin
      valE = '0;
      case (icode)
         I_RRMOVQ:         valE = valA;
         I_IRMOVQ:         valE = valC;
         I_RMMOVQ,
         I_MRMOVQ:         valE = valB + valC;
         I_OPQ:            valE = unsigned'(aluOut);
         I_CALL, I_PUSHQ:  valE = valB - STACK_STEP;
         I_RET,  I_POPQ:   valE = valB + STACK_STEP;
         default:          valE = '0;
      endcase
   end

   // Overflow: operands of the effective addition share a sign that the result lacks.
   always_comb begin
      nextOF = 1'b0;
      case (ifun)
         ALU_ADD: nextOF = (valA[W-1] == valB[W-1]) && (aluOut[W-1] != valA[W-1]);
         ALU_SUB: nextOF = (valA[W-1] != valB[W-1]) && (aluOut[W-1] != valB[W-1]);
         default: nextOF = 1'b0;
      endcase
   end

   assign ccWrite = (icode == I_OPQ) && (ifun <= ALU_XOR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ZF <= 1'b1;
         SF <= 1'b0;
         OF <= 1'b0;
      end else if (ccWrite) begin
         ZF <= (aluOut == '0);
         SF <= aluOut[W-1];
         OF <= nextOF;
      end
   end

   assign Cnd = ((icode == I_RRMOVQ) || (icode == I_JXX)) ? evalCond(ifun, ZF, SF, OF) : 1'b0;

endmodule

// File: tb/tb_execute.sv
// Bench for the Y86-64 execute stage: table of single-cycle vectors checked
// through an expected-value queue, plus hand-built async reset sequences.
module tb_execute;

   logic        clk;
   logic        rst;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic [63:0] valA;
   logic [63:0] valB;
   logic [63:0] valC;
   logic [63:0] valE;
   logic        Cnd;
   logic        OF;
   logic        ZF;
   logic        SF;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] c;
      logic [63:0] expE;
      logic        expCnd;
      logic        expZ;
      logic        expS;
      logic        expO;
   } vec_t;

   typedef struct {
      logic [63:0] e;
      logic        cnd;
      logic        z;
      logic        s;
      logic        o;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   execute #(.W(64)) dut (
      .clk(clk), .rst(rst), .icode(icode), .ifun(ifun),
      .valA(valA), .valB(valB), .valC(valC),
      .valE(valE), .Cnd(Cnd), .OF(OF), .ZF(ZF), .SF(SF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic checkCC(input string name, input logic z, input logic s, input logic o);
      check({name, ".ZF"}, {63'd0, ZF}, {63'd0, z});
      check({name, ".SF"}, {63'd0, SF}, {63'd0, s});
      check({name, ".OF"}, {63'd0, OF}, {63'd0, o});
   endtask

   function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn,
                               input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                               input logic [63:0] e, input logic cnd,
                               input logic z, input logic s, input logic o);
      vec_t v;
      v.icode = ic; v.ifun = fn; v.a = a; v.b = b; v.c = c;
      v.expE = e; v.expCnd = cnd; v.expZ = z; v.expS = s; v.expO = o;
      return v;
   endfunction

   initial begin
      exp_t ex;
      string nm;
      rst = 1'b0; icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0;

      // icode sweep with A=5 B=3 C=7; CC stays at reset values
      vecs.push_back(mk(4'h0, 4'h0, 64'd5, 64'd3, 64'd7, 64'd0,  1'b0, 1, 0, 0));
      vecs.push_back(mk(4'h1, 4'h0, 64'd5, 64'd3, 64'd7, 64'd0,  1'b0, 1, 0, 0));
      vecs.push_back(mk(4'h2, 4'h0, 64'd5, 64'd3, 64'd7, 64'd5,  1'b1, 1, 0, 0));
      vecs.push_back(mk(4'h3, 4'h0, 64'd5, 64'd3, 64'd7, 64'd7,  1'b0, 1, 0, 0));
      vecs.push_back(mk(4'h4, 4'h0, 64'd5, 64'd3, 64'd7, 64'd10, 1'b0, 1, 0, 0));
      vecs.push_back(mk(4'h5, 4'h0, 64'd5, 64'd3, 64'd7, 64'd10, 1'b0, 1, 0, 0));
      vecs.push_back(mk(4'h7, 4'h0, 64'd5, 64'd3, 64'd7, 64'd0,  1'b1, 1, 0, 0));
      vecs.push_back(mk(4'h8, 4'h0, 64'd5, 64'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1, 0, 0));
      vecs.push_back(mk(4'h9, 4'h0, 64'd5, 64'd3, 64'd7, 64'd11, 1'b0, 1, 0, 0));
      vecs.push_back(mk(4'hA, 4'h0, 64'd5, 64'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1, 0, 0));
      vecs.push_back(mk(4'hB, 4'h0, 64'd5, 64'd3, 64'd7, 64'd11, 1'b0, 1, 0, 0));
      vecs.push_back(mk(4'hC, 4'h0, 64'd5, 64'd3, 64'd7, 64'd0,  1'b0, 1, 0, 0));
      vecs.push_back(mk(4'hF, 4'h0, 64'd5, 64'd3, 64'd7, 64'd0,  1'b0, 1, 0, 0));
      // OPq A=5 B=3
      vecs.push_back(mk(4'h6, 4'h0, 64'd5, 64'd3, 64'd0, 64'd8, 1'b0, 0, 0, 0));
      vecs.push_back(mk(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0, 1, 0));
      vecs.push_back(mk(4'h6, 4'h2, 64'd5, 64'd3, 64'd0, 64'd1, 1'b0, 0, 0, 0));
      vecs.push_back(mk(4'h6, 4'h3, 64'd5, 64'd3, 64'd0, 64'd6, 1'b0, 0, 0, 0));
      vecs.push_back(mk(4'h6, 4'h4, 64'd5, 64'd3, 64'd0, 64'd0, 1'b0, 0, 0, 0));
      // add overflow, then l / ge
      vecs.push_back(mk(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 1'b0, 0, 1, 1));
      vecs.push_back(mk(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 0, 1, 1));
      vecs.push_back(mk(4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 0, 1, 1));
      // sub to zero, then conditions
      vecs.push_back(mk(4'h6, 4'h1, 64'd9, 64'd9, 64'd0, 64'd0, 1'b0, 1, 0, 0));
      vecs.push_back(mk(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1, 0, 0));
      vecs.push_back(mk(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1, 0, 0));
      vecs.push_back(mk(4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1, 0, 0));
      vecs.push_back(mk(4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1, 0, 0));
      vecs.push_back(mk(4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1, 0, 0));
      vecs.push_back(mk(4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1, 0, 0));
      // sub overflow (positive result from negative minus positive)
      vecs.push_back(mk(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 0, 0, 1));
      vecs.push_back(mk(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 0, 0, 1));
      // sub A=5 B=3, then cmov conditions
      vecs.push_back(mk(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0, 1, 0));
      vecs.push_back(mk(4'h2, 4'h2, 64'd5, 64'd3, 64'd7, 64'd5,  1'b1, 0, 1, 0));
      vecs.push_back(mk(4'h2, 4'h5, 64'd5, 64'd3, 64'd7, 64'd5,  1'b0, 0, 1, 0));
      vecs.push_back(mk(4'h4, 4'h2, 64'd5, 64'd3, 64'd7, 64'd10, 1'b0, 0, 1, 0));
      vecs.push_back(mk(4'h2, 4'h1, 64'd5, 64'd3, 64'd7, 64'd5,  1'b1, 0, 1, 0));
      vecs.push_back(mk(4'h2, 4'h6, 64'd5, 64'd3, 64'd7, 64'd5,  1'b0, 0, 1, 0));
      vecs.push_back(mk(4'h2, 4'h4, 64'd5, 64'd3, 64'd7, 64'd5,  1'b1, 0, 1, 0));

      // async reset with no clock edge
      #2 rst = 1'b1;
      #1 checkCC("reset", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         icode = vecs[i].icode; ifun = vecs[i].ifun;
         valA = vecs[i].a; valB = vecs[i].b; valC = vecs[i].c;
         sb.push_back('{e: vecs[i].expE, cnd: vecs[i].expCnd,
                        z: vecs[i].expZ, s: vecs[i].expS, o: vecs[i].expO});
         #1;
         ex = sb.pop_front();
         nm = $sformatf("v%0d", i);
         check({nm, ".valE"}, valE, ex.e);
         check({nm, ".Cnd"}, {63'd0, Cnd}, {63'd0, ex.cnd});
         @(posedge clk);
         #1 checkCC(nm, ex.z, ex.s, ex.o);
      end

      // mid-cycle reset pulse while CC holds ZF=0 SF=1; OPq held during reset
      @(negedge clk);
      icode = 4'h6; ifun = 4'h0; valA = 64'd1; valB = 64'h7FFF_FFFF_FFFF_FFFF;
      #1 rst = 1'b1;
      #1 checkCC("asyncRst", 1'b1, 1'b0, 1'b0);
      check("asyncRst.valE", valE, 64'h8000_0000_0000_0000);
      @(posedge clk);
      #1 checkCC("rstWinsEdge", 1'b1, 1'b0, 1'b0);
      #1 rst = 1'b0;
      icode = 4'h1;
      #1 checkCC("rstRelease", 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1 checkCC("nopAfterRst", 1'b1, 1'b0, 1'b0);
      icode = 4'h6; ifun = 4'h0;
      @(posedge clk);
      #1 checkCC("opqAfterRst", 1'b0, 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/execute.md
Name: execute

Overview:
- Execute stage of the Y86-64 sequential (SEQ) processor.
- The ALU computes valE combinationally from icode/ifun and the operand values valA, valB, valC.
- The block holds the condition-code register (OF, ZF, SF). It updates only on OPq instructions and reports the branch/move condition Cnd for jXX and cmovXX.
- Sits between decode (which supplies valA/valB/valC) and memory/write-back (which consume valE and Cnd).

Parameters:
- W, 64, datapath width in bits. Only 64 is supported.

Ports:
- clk  input  1  system clock; CC register updates on the rising edge.
- rst  input  1  asynchronous active-high reset of the CC register.
- icode  input  4  instruction code.
- ifun  input  4  function code (ALU op or condition).
- valA  input  64  operand A from register file.
- valB  input  64  operand B from register file.
- valC  input  64  instruction constant.
- valE  output  64  ALU result, combinational.
- Cnd  output  1  condition result, combinational from the registered CC.
- OF  output  1  registered overflow flag.
- ZF  output  1  registered zero flag.
- SF  output  1  registered sign flag.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst=1: ZF=1, SF=0, OF=0, taking effect immediately without waiting for a clock edge. valE and Cnd remain combinational during reset.
- valE by icode (all arithmetic modulo 2^64, wrap-around ignored):
  - 0x0 halt, 0x1 nop, 0x7 jXX: 0.
  - 0x2 rrmovq/cmovXX: valA.
  - 0x3 irmovq: valC.
  - 0x4 rmmovq, 0x5 mrmovq: valB+valC.
  - 0x6 OPq: ifun 0 gives valB+valA; 1 gives valB−valA; 2 gives valB&valA; 3 gives valB^valA; ifun>3 gives 0.
  - 0x8 call, 0xA pushq: valB−8.
  - 0x9 ret, 0xB popq: valB+8.
  - 0xC–0xF: 0.
- CC update, on the rising clk edge when rst=0, icode=0x6 and ifun≤3:
  - ZF = (valE==0).
  - SF = valE[63].
  - OF for add: valA[63]==valB[63] and valE[63]!=valA[63].
  - OF for sub: valA[63]!=valB[63] and valE[63]!=valB[63].
  - OF for and/xor: 0.
  - Any other icode/ifun: CC holds.
- Cnd:
  - Evaluated from the current registered CC, not the value being written on the same edge.
  - Only icode 0x2 and 0x7 produce a non-zero Cnd; all other icodes give Cnd=0.
  - ifun 0 always: 1.
  - ifun 1 le: (SF^OF)|ZF.
  - ifun 2 l: SF^OF.
  - ifun 3 e: ZF.
  - ifun 4 ne: !ZF.
  - ifun 5 ge: !(SF^OF).
  - ifun 6 g: !(SF^OF)&!ZF.
  - ifun 7–15: 0.
- Latency: valE and Cnd have zero latency, settling within the same cycle as the inputs. CC reflects an OPq one clock edge later.
- Simultaneous events:
  - rst=1 at a clock edge with an OPq present: reset wins.
  - rst deasserted mid-cycle: CC keeps reset values until the next qualifying edge.

Test Plan:
- valA=5, valB=3, valC=7, ifun=0, sweep icode -> valE checks:
  - icode 2: 5.
  - icode 3: 7.
  - icode 4 and 5: 10.
  - icode 8 and 0xA: 0xFFFFFFFFFFFFFFFB.
  - icode 9 and 0xB: 11.
  - CC unchanged throughout: ZF=1, SF=0, OF=0 after reset.
- icode=6, valA=5, valB=3, ifun 0/1/2/3, one clock each -> valE and CC after each edge:
  - ifun 0: valE=8, ZF=0 SF=0 OF=0.
  - ifun 1: valE=0xFFFFFFFFFFFFFFFE, SF=1 ZF=0 OF=0.
  - ifun 2: valE=1, SF=0.
  - ifun 3: valE=6, SF=0.
- Overflow: add with valA=1, valB=0x7FFFFFFFFFFFFFFF -> valE=0x8000000000000000; after the edge OF=1, SF=1, ZF=0.
- Sub with valA=valB=9 -> valE=0, ZF=1 after the edge. Then icode=7:
  - ifun 3 gives Cnd=1.
  - ifun 4 gives Cnd=0.
  - ifun 6 gives Cnd=0.
  - ifun 5 gives Cnd=1.
- Sub with valA=5, valB=3 (SF=1, OF=0), then icode=2 -> Cnd checks:
  - ifun 2 (l) gives Cnd=1.
  - ifun 5 (ge) gives Cnd=0.
  - icode=4 with any ifun gives Cnd=0.
- Async reset mid-cycle, after CC has been set to ZF=0, SF=1: pulse rst between clock edges -> ZF=1, SF=0, OF=0 immediately. An OPq presented with rst=1 at the edge leaves CC at the reset values.
